// File: rtl/mux16_scan_capture_if.sv
// Bundle between the scan sequencer, the upstream 16:1 mux and the word consumer.
// The sequencer connects through master; the surrounding logic connects through slave.
interface mux16_scan_capture_if;
   logic [3:0]  sel;
   logic        y_in;
   logic        start;
   logic        cont;
   logic [15:0] data;
   logic        valid;
   logic        ready;
   logic        busy;
   logic        missed;

   modport master (
      input  y_in, start, cont, ready,
      output sel, data, valid, busy, missed
   );

   modport slave (
      output y_in, start, cont, ready,
      input  sel, data, valid, busy, missed
   );
endinterface

// File: rtl/mux16_scan_capture.sv
// Walks a 16:1 mux select through channels 0..15, samples each after a settle time,
// and hands the assembled word to a consumer over valid/ready.
module mux16_scan_capture #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   mux16_scan_capture_if.master  bus
);

   localparam int unsigned CH_W   = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned WORD_W = 16;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(WORD_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e              state_q,  state_d;
   logic [CH_W-1:0]     ch_q,     ch_d;
   logic [CNT_W-1:0]    settle_q, settle_d;
   logic [WORD_W-1:0]   shadow_q, shadow_d;
   logic [WORD_W-1:0]   data_q,   data_d;
   logic                valid_q,  valid_d;
   logic                busy_q,   busy_d;
   logic                missed_q, missed_d;

   // Next-state and output logic; ch_q doubles as the select, so it is 0 outside SCAN.
   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      settle_d = settle_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      missed_d = bus.start && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (bus.start || bus.cont) begin
               state_d  = SCAN;
               ch_d     = '0;
               settle_d = '0;
               busy_d   = 1'b1;
            end
         end

         SCAN: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d       = '0;
               shadow_d[ch_q] = bus.y_in;
               if (ch_q == CH_LAST) begin
                  // Publish the word including the bit captured on this edge.
                  data_d  = shadow_d;
                  valid_d = 1'b1;
                  busy_d  = 1'b0;
                  ch_d    = '0;
                  state_d = HOLD;
               end else begin
                  ch_d = ch_q + CH_W'(1);
               end
            end else begin
               settle_d = settle_q + CNT_W'(1);
            end
         end

         HOLD: begin
            if (bus.ready) begin
               valid_d = 1'b0;
               if (bus.cont) begin
                  state_d  = SCAN;
                  ch_d     = '0;
                  settle_d = '0;
                  busy_d   = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d  = IDLE;
            ch_d     = '0;
            settle_d = '0;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   // Reset discards any partial word held in the shadow register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ch_q     <= '0;
         settle_q <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         settle_q <= settle_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         missed_q <= missed_d;
      end
   end

   assign bus.sel    = ch_q;
   assign bus.data   = data_q;
   assign bus.valid  = valid_q;
   assign bus.busy   = busy_q;
   assign bus.missed = missed_q;

endmodule

// File: tb/tb_mux16_scan_capture.sv
// Bench for mux16_scan_capture: one instance with a 1-cycle settle, one with 3,
// each fed by a behavioural 16:1 mux, checked against timing formulas.
module tb_mux16_scan_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] d_a;
   logic [15:0] d_b;
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] last_word [2];

   mux16_scan_capture_if ifa ();
   mux16_scan_capture_if ifb ();

   assign ifa.y_in = d_a[ifa.sel];
   assign ifb.y_in = d_b[ifb.sel];

   mux16_scan_capture #(.SETTLE_CYCLES(1)) u_a (.clk(clk), .rst(rst), .bus(ifa.master));
   mux16_scan_capture #(.SETTLE_CYCLES(3)) u_b (.clk(clk), .rst(rst), .bus(ifb.master));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input int u, input logic v);
      if (u == 0) ifa.start = v; else ifb.start = v;
   endtask

   task automatic set_ready(input int u, input logic v);
      if (u == 0) ifa.ready = v; else ifb.ready = v;
   endtask

   task automatic set_d(input int u, input logic [15:0] v);
      if (u == 0) d_a = v; else d_b = v;
   endtask

   task automatic expect_state(input int u, input string tag, input logic [3:0] sel,
                               input logic busy, input logic valid, input logic missed,
                               input logic [15:0] data);
      string p;
      p = $sformatf("u%0d.%s", u, tag);
      if (u == 0) begin
         chk({p, ".sel"},    16'(ifa.sel),    16'(sel));
         chk({p, ".busy"},   16'(ifa.busy),   16'(busy));
         chk({p, ".valid"},  16'(ifa.valid),  16'(valid));
         chk({p, ".missed"}, 16'(ifa.missed), 16'(missed));
         chk({p, ".data"},   ifa.data,        data);
      end else begin
         chk({p, ".sel"},    16'(ifb.sel),    16'(sel));
         chk({p, ".busy"},   16'(ifb.busy),   16'(busy));
         chk({p, ".valid"},  16'(ifb.valid),  16'(valid));
         chk({p, ".missed"}, 16'(ifb.missed), 16'(missed));
         chk({p, ".data"},   ifb.data,        data);
      end
   endtask

   // One full scan: sel = k/S for k < 16S, word published after 16S edges,
   // held for hold_cycles with ready low, then acknowledged back to IDLE.
   task automatic run_scan(input int u, input logic [15:0] dval, input int hold_cycles,
                           input int start_at);
      int s;
      int n;
      s = (u == 0) ? 1 : 3;
      n = 16 * s;
      set_d(u, dval);
      expect_state(u, "idle", 4'd0, 1'b0, 1'b0, 1'b0, last_word[u]);
      set_start(u, 1'b1);
      tick();
      for (int k = 0; k < n; k++) begin
         expect_state(u, "scan", 4'(k / s), 1'b1, 1'b0, (k > 0) && (k - 1 == start_at),
                      last_word[u]);
         set_start(u, k == start_at);
         set_ready(u, 1'($urandom % 2));
         if (s > 1) set_d(u, (k % s == 0) ? ~dval : dval);
         tick();
      end
      set_start(u, 1'b0);
      set_ready(u, 1'b0);
      set_d(u, dval);
      expect_state(u, "done", 4'd0, 1'b0, 1'b1, start_at == n - 1, dval);
      last_word[u] = dval;
      for (int h = 0; h < hold_cycles; h++) begin
         tick();
         expect_state(u, "hold", 4'd0, 1'b0, 1'b1, 1'b0, dval);
      end
      set_ready(u, 1'b1);
      tick();
      set_ready(u, 1'b0);
      expect_state(u, "ack", 4'd0, 1'b0, 1'b0, 1'b0, dval);
      tick();
      expect_state(u, "idle_after", 4'd0, 1'b0, 1'b0, 1'b0, dval);
   endtask

   initial begin
      logic [3:0]  exp_sel;
      logic [15:0] exp_data;
      logic        exp_v;
      int          s;

      rst = 1'b1;
      d_a = '0;
      d_b = '0;
      ifa.start = 1'b0; ifa.cont = 1'b0; ifa.ready = 1'b0;
      ifb.start = 1'b0; ifb.cont = 1'b0; ifb.ready = 1'b0;
      last_word[0] = '0;
      last_word[1] = '0;
      tick();
      tick();
      expect_state(0, "reset", 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
      expect_state(1, "reset", 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
      rst = 1'b0;
      tick();

      // Basic scan, then backpressure, then the 3-cycle settle instance.
      run_scan(0, 16'hA5C3, 0, -1);
      run_scan(0, 16'hA5C3, 10, -1);
      run_scan(1, 16'h8001, 2, -1);

      // Start while busy, raised while sel == 5.
      run_scan(0, 16'($urandom), 1, 5);
      run_scan(1, 16'($urandom), 0, 5 * 3);

      // Continuous mode: two back-to-back words with a one-cycle HOLD each.
      d_a = 16'h1234;
      ifa.cont  = 1'b1;
      ifa.ready = 1'b1;
      tick();
      for (int k = 0; k < 34; k++) begin
         exp_v    = (k == 16) || (k == 33);
         exp_sel  = (k < 16) ? 4'(k) : ((k > 16 && k < 33) ? 4'(k - 17) : 4'd0);
         exp_data = (k < 16) ? last_word[0] : ((k < 33) ? 16'h1234 : 16'hFEDC);
         expect_state(0, "cont", exp_sel, !exp_v, exp_v, 1'b0, exp_data);
         if (k == 17) d_a = 16'hFEDC;
         if (k == 33) ifa.cont = 1'b0;
         tick();
      end
      ifa.ready = 1'b0;
      last_word[0] = 16'hFEDC;
      expect_state(0, "cont_end", 4'd0, 1'b0, 1'b0, 1'b0, 16'hFEDC);
      tick();
      expect_state(0, "cont_idle", 4'd0, 1'b0, 1'b0, 1'b0, 16'hFEDC);

      // Reset while sel == 7 aborts the scan and clears the published word.
      d_a = 16'h5A5A;
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      repeat (7) tick();
      expect_state(0, "pre_rst", 4'd7, 1'b1, 1'b0, 1'b0, last_word[0]);
      rst = 1'b1;
      ifa.ready = 1'b1;
      tick();
      rst = 1'b0;
      ifa.ready = 1'b0;
      last_word[0] = '0;
      last_word[1] = '0;
      expect_state(0, "rst", 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
      expect_state(1, "rst", 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int k = 0; k < 20; k++) begin
         tick();
         expect_state(0, "post_rst", 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
      end
      run_scan(0, 16'h00FF, 0, -1);

      // Randomized words, hold lengths and stray starts on both instances.
      for (int i = 0; i < 12; i++) begin
         s = (i % 2 == 0) ? 1 : 3;
         run_scan(i % 2, 16'($urandom), int'($urandom % 4),
                  ($urandom % 2 == 1) ? int'($urandom % (16 * s)) : -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
